alu8_seq: RTL

- Multi-cycle ALU operation sequencer: the driver side of the 8-bit ALU's OP/CI/CO interface.
- Accepts a 6502-style arithmetic/logic request, drives the ALU, and registers the result and N/Z/C/V flags.
- Performs the decimal (BCD) correction pass for ADC/SBC when D=1 by issuing a second ALU operation.
- Sits between the CPU control unit and one 8-bit ALU instance.

---
 rtl/alu8_seq.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/alu8_seq.sv
// alu8_seq: multi-cycle 6502-style ALU sequencer driving an external 8-bit ALU.
// Registers the result and N/Z/C/V flags; decimal ADC/SBC take an extra BCD adjust pass.
`timescale 1ns/1ps
module alu8_seq (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_start,
    input  logic [3:0] i_func,
    input  logic [7:0] i_a_in,
    input  logic [7:0] i_b_in,
    input  logic       i_c_in,
    input  logic       i_d_in,
    output logic [7:0] o_alu_a,
    output logic [7:0] o_alu_b,
    output logic       o_alu_ci,
    output logic [7:0] o_alu_op,
    input  logic [7:0] i_alu_f,
    input  logic       i_alu_co,
    output logic [7:0] o_result,
    output logic       o_n_out,
    output logic       o_z_out,
    output logic       o_c_out,
    output logic       o_v_out,
    output logic       o_busy,
    output logic       o_done
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_ADJ  = 2'd2;

    localparam logic [3:0] F_ORA = 4'h0, F_AND = 4'h1, F_EOR = 4'h2, F_ADC = 4'h3;
    localparam logic [3:0] F_SBC = 4'h4, F_CMP = 4'h5, F_ASL = 4'h6, F_LSR = 4'h7;
    localparam logic [3:0] F_ROL = 4'h8, F_ROR = 4'h9, F_INC = 4'hA, F_DEC = 4'hB;
    localparam logic [3:0] F_BIT = 4'hC, F_PASSB = 4'hD;

    logic [1:0] r_state;
    logic [3:0] r_func;
    logic [7:0] r_a, r_b, r_adj_b, r_result;
    logic       r_c, r_d, r_adj_c, r_adj_v;
    logic       r_n, r_z, r_cf, r_v, r_done;

    logic [1:0] w_state_nxt;
    logic [7:0] w_op, w_adj_b, w_result_nxt;
    logic       w_ci, w_load, w_is_adc, w_is_sbc, w_decimal, w_h;
    logic       w_f_gt99, w_lo_gt9, w_v_add, w_v_sub;
    logic       w_n_nxt, w_z_nxt, w_c_nxt, w_v_nxt, w_done_nxt;

    assign w_is_adc  = (r_func == F_ADC);
    assign w_is_sbc  = (r_func == F_SBC);
    assign w_decimal = r_d && (w_is_adc || w_is_sbc);
    // XOR of operand and result bit 4 is the carry/borrow out of the low nibble
    assign w_h       = r_a[4] ^ r_b[4] ^ i_alu_f[4];
    assign w_f_gt99  = (i_alu_f > 8'h99);
    assign w_lo_gt9  = (i_alu_f[3:0] > 4'd9);
    assign w_v_add   = (r_a[7] == r_b[7]) && (i_alu_f[7] != r_a[7]);
    assign w_v_sub   = (r_a[7] != r_b[7]) && (i_alu_f[7] != r_a[7]);
    assign w_adj_b   = w_is_sbc ?
                       {(!i_alu_co ? 4'h6 : 4'h0), (w_h ? 4'h6 : 4'h0)} :
                       {((i_alu_co || w_f_gt99) ? 4'h6 : 4'h0),
                        ((w_h || w_lo_gt9) ? 4'h6 : 4'h0)};

    assign o_alu_a  = r_a;
    assign o_alu_b  = (r_state == S_ADJ) ? r_adj_b : r_b;
    assign o_alu_op = w_op;
    assign o_alu_ci = w_ci;
    assign o_result = r_result;
    assign o_n_out  = r_n;
    assign o_z_out  = r_z;
    assign o_c_out  = r_cf;
    assign o_v_out  = r_v;
    assign o_busy   = (r_state == S_EXEC) || (r_state == S_ADJ);
    assign o_done   = r_done;

    always_comb begin
        w_op = 8'h1F;
        w_ci = 1'b0;
        if (r_state == S_EXEC) begin
            case (r_func)
                F_ORA:   w_op = 8'h1E;
                F_AND:   w_op = 8'h1B;
                F_EOR:   w_op = 8'h16;
                F_ADC:   begin w_op = 8'h09; w_ci = r_c;  end
                F_SBC:   begin w_op = 8'h06; w_ci = r_c;  end
                F_CMP:   begin w_op = 8'h06; w_ci = 1'b1; end
                F_ASL:   w_op = 8'h40;
                F_LSR:   w_op = 8'h20;
                F_ROL:   w_op = {r_c, 7'h40};
                F_ROR:   w_op = {r_c, 7'h20};
                F_INC:   begin w_op = 8'h00; w_ci = 1'b1; end
                F_DEC:   w_op = 8'h0F;
                F_BIT:   w_op = 8'h1B;
                F_PASSB: w_op = 8'h1A;
                default: w_op = 8'h1F;
            endcase
        end else if (r_state == S_ADJ) begin
            w_op = w_is_sbc ? 8'h06 : 8'h09;
            w_ci = w_is_sbc;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_load       = 1'b0;
        w_done_nxt   = 1'b0;
        w_result_nxt = r_result;
        w_n_nxt      = r_n;
        w_z_nxt      = r_z;
        w_c_nxt      = r_cf;
        w_v_nxt      = r_v;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                if (w_decimal) begin
                    w_state_nxt = S_ADJ;
                end else begin
                    w_state_nxt  = S_IDLE;
                    w_done_nxt   = 1'b1;
                    w_result_nxt = i_alu_f;
                    w_n_nxt      = i_alu_f[7];
                    w_z_nxt      = (i_alu_f == 8'h00);
                    case (r_func)
                        F_ADC: begin w_c_nxt = i_alu_co; w_v_nxt = w_v_add; end
                        F_SBC: begin w_c_nxt = i_alu_co; w_v_nxt = w_v_sub; end
                        F_CMP: begin w_c_nxt = i_alu_co; w_result_nxt = r_a; end
                        F_ASL, F_LSR, F_ROL, F_ROR: w_c_nxt = i_alu_co;
                        F_BIT: begin
                            w_result_nxt = r_a;
                            w_n_nxt      = r_b[7];
                            w_z_nxt      = ((r_a & r_b) == 8'h00);
                            w_v_nxt      = r_b[6];
                        end
                        F_ORA, F_AND, F_EOR, F_INC, F_DEC, F_PASSB: ;
                        default: begin
                            w_result_nxt = r_a;
                            w_n_nxt      = r_n;
                            w_z_nxt      = r_z;
                        end
                    endcase
                end
            end
            S_ADJ: begin
                w_state_nxt  = S_IDLE;
                w_done_nxt   = 1'b1;
                w_result_nxt = i_alu_f;
                w_n_nxt      = i_alu_f[7];
                w_z_nxt      = (i_alu_f == 8'h00);
                w_c_nxt      = r_adj_c;
                w_v_nxt      = r_adj_v;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= S_IDLE;
            r_func   <= 4'h0;
            r_a      <= 8'h00;
            r_b      <= 8'h00;
            r_c      <= 1'b0;
            r_d      <= 1'b0;
            r_adj_b  <= 8'h00;
            r_adj_c  <= 1'b0;
            r_adj_v  <= 1'b0;
            r_result <= 8'h00;
            r_n      <= 1'b0;
            r_z      <= 1'b0;
            r_cf     <= 1'b0;
            r_v      <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_done   <= w_done_nxt;
            r_result <= w_result_nxt;
            r_n      <= w_n_nxt;
            r_z      <= w_z_nxt;
            r_cf     <= w_c_nxt;
            r_v      <= w_v_nxt;
            if (w_load) begin
                r_func <= i_func;
                r_a    <= i_a_in;
                r_b    <= i_b_in;
                r_c    <= i_c_in;
                r_d    <= i_d_in;
            end else if (r_state == S_EXEC && w_decimal) begin
                // Binary result becomes the A operand of the adjust pass
                r_a     <= i_alu_f;
                r_adj_b <= w_adj_b;
                r_adj_c <= w_is_sbc ? i_alu_co : (i_alu_co || w_f_gt99);
                r_adj_v <= w_is_sbc ? w_v_sub : w_v_add;
            end
        end
    end
endmodule
